// File: rtl/sound_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sound_pkg
// Purpose  : Shared audio types for the codec receive/transmit/pitch chain.
// Revision : 1.0
// ============================================================================
package sound_pkg;

    localparam int CHANNEL_LENGTH = 16;

    typedef logic signed [CHANNEL_LENGTH-1:0] sample_t;
    typedef logic        [CHANNEL_LENGTH-1:0] mag_t;

    typedef enum logic [0:0] {
        S_ACC = 1'b0,
        S_CMP = 1'b1
    } state_t;

    function automatic mag_t mag_max(input mag_t a, input mag_t b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sound_abs_sat.sv
`default_nettype none
// ============================================================================
// Module   : sound_abs_sat
// Purpose  : Combinational saturated magnitude; -32768 clamps to 32767.
// Revision : 1.0
// ============================================================================
module sound_abs_sat
    import sound_pkg::*;
(
    input  sample_t i_sample,
    output mag_t    o_mag
);

    localparam sample_t c_most_neg = {1'b1, {(CHANNEL_LENGTH-1){1'b0}}};
    localparam mag_t    c_most_pos = {1'b0, {(CHANNEL_LENGTH-1){1'b1}}};

    always_comb begin
        o_mag = mag_t'(i_sample);
        if (i_sample == c_most_neg) begin
            o_mag = c_most_pos;
        end else if (i_sample[CHANNEL_LENGTH-1]) begin
            o_mag = mag_t'(-i_sample);
        end
    end

endmodule
`default_nettype wire

// File: rtl/sound_onset_detector.sv
`default_nettype none
// ============================================================================
// Module   : sound_onset_detector
// Purpose  : Windowed |sample| energy/peak with ratio+threshold onset pulse.
// Revision : 1.0
// ============================================================================
module sound_onset_detector
    import sound_pkg::*;
#(
    parameter int WIN_LOG2    = 8,
    parameter int RATIO_SHIFT = 1,
    parameter int HOLDOFF     = 2,
    parameter int ENERGY_W    = 16 + WIN_LOG2
) (
    input  logic                i_bclk,
    input  logic                i_rst_n,
    input  logic                i_adclrck,
    input  logic [15:0]         i_sound,
    input  logic [ENERGY_W-1:0] i_thresh,
    output logic [ENERGY_W-1:0] o_energy,
    output logic [15:0]         o_peak,
    output logic                o_energy_valid,
    output logic                o_onset
);

    localparam int c_hold_w = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
    localparam int c_cmp_w  = ENERGY_W + RATIO_SHIFT;
    localparam logic [WIN_LOG2-1:0] c_cnt_last = '1;
    localparam logic [c_hold_w-1:0] c_hold_load = c_hold_w'(HOLDOFF);

    logic                r_lr_q;
    logic [ENERGY_W-1:0] r_acc;
    mag_t                r_peak_acc;
    logic [WIN_LOG2-1:0] r_cnt;
    logic [ENERGY_W-1:0] r_cur;
    mag_t                r_pk;
    logic [ENERGY_W-1:0] r_prev;
    logic [c_hold_w-1:0] r_hold;
    state_t              r_state;
    state_t              w_state_next;

    mag_t                w_mag;
    mag_t                w_peak_next;
    logic [ENERGY_W-1:0] w_acc_next;
    logic                w_sample_evt;
    logic                w_close;
    logic [c_cmp_w-1:0]  w_prev_scaled;
    logic                w_onset;

    sound_abs_sat u_abs_sat (
        .i_sample (sample_t'(i_sound)),
        .o_mag    (w_mag)
    );

    // Left word is complete on the rising LR edge; falling edges are ignored.
    assign w_sample_evt  = i_adclrck & ~r_lr_q;
    assign w_close       = w_sample_evt && (r_cnt == c_cnt_last);
    assign w_acc_next    = r_acc + ENERGY_W'(w_mag);
    assign w_peak_next   = mag_max(r_peak_acc, w_mag);
    assign w_prev_scaled = c_cmp_w'(r_prev) << RATIO_SHIFT;
    assign w_onset       = (r_cur > i_thresh)
                        && (c_cmp_w'(r_cur) > w_prev_scaled)
                        && (r_hold == '0);

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lr_q     <= 1'b0;
            r_acc      <= '0;
            r_peak_acc <= '0;
            r_cnt      <= '0;
            r_cur      <= '0;
            r_pk       <= '0;
        end else begin
            r_lr_q <= i_adclrck;
            if (w_close) begin
                r_cur      <= w_acc_next;
                r_pk       <= w_peak_next;
                r_acc      <= '0;
                r_peak_acc <= '0;
                r_cnt      <= '0;
            end else if (w_sample_evt) begin
                r_acc      <= w_acc_next;
                r_peak_acc <= w_peak_next;
                r_cnt      <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_ACC:   if (w_close) w_state_next = S_CMP;
            S_CMP:   w_state_next = S_ACC;
            default: w_state_next = S_ACC;
        endcase
    end

    // Publish and compare during the single S_CMP cycle after window close.
    always_ff @(posedge i_bclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_energy       <= '0;
            o_peak         <= '0;
            o_energy_valid <= 1'b0;
            o_onset        <= 1'b0;
            r_prev         <= '0;
            r_hold         <= '0;
        end else begin
            o_energy_valid <= 1'b0;
            o_onset        <= 1'b0;
            if (r_state == S_CMP) begin
                o_energy       <= r_cur;
                o_peak         <= r_pk;
                o_energy_valid <= 1'b1;
                o_onset        <= w_onset;
                r_prev         <= r_cur;
                if (w_onset) begin
                    r_hold <= c_hold_load;
                end else if (r_hold != '0) begin
                    r_hold <= r_hold - 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire
